// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for an external
// combinational ALU. Takes one operation at a time, gives the ALU one
// cycle to settle, registers its outputs and holds the response until
// the consumer accepts it.
module alu_arbiter #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [SEL_W-1:0]  r0_sel,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [SEL_W-1:0]  r1_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [15:0]       alu_result,
    input  logic              alu_carry,
    input  logic              alu_zflag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [15:0]       rsp_result,
    output logic              rsp_carry,
    output logic              rsp_zflag,
    output logic              busy,
    output logic [7:0]        ops_done
);

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              grant_any;
    logic              grant_id;
    logic              accept;
    logic [DATA_W-1:0] lat_a;
    logic [DATA_W-1:0] lat_b;
    logic [SEL_W-1:0]  lat_sel;
    logic              lat_id;
    logic              carry_pass;

    // Round-robin choice: with both pending, take the one not served last
    always_comb begin
        grant_any = r0_valid | r1_valid;
        grant_id  = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_id = ~last_grant;
        end else if (r1_valid) begin
            grant_id = 1'b1;
        end
        accept = (state == IDLE) && grant_any && !rst;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant, one settle cycle, capture, then wait for the consumer
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_any) state_next = EXEC;
            EXEC: state_next = CAPT;
            CAPT: state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: readies only on the grant cycle, status from the state
    always_comb begin
        r0_ready  = accept && !grant_id;
        r1_ready  = accept && grant_id;
        busy      = (state != IDLE);
        rsp_valid = (state == RESP);
    end

    // Only add and subtract produce a meaningful carry
    always_comb begin
        carry_pass = (lat_sel == SEL_W'(0)) || (lat_sel == SEL_W'(1));
    end

    // Operand latch, response capture, grant pointer and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_a      <= '0;
            lat_b      <= '0;
            lat_sel    <= '0;
            lat_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zflag  <= 1'b0;
            ops_done   <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                lat_id     <= grant_id;
                lat_a      <= grant_id ? r1_a : r0_a;
                lat_b      <= grant_id ? r1_b : r0_b;
                lat_sel    <= grant_id ? r1_sel : r0_sel;
            end
            if (state == CAPT) begin
                rsp_result <= alu_result;
                rsp_zflag  <= alu_zflag;
                rsp_carry  <= carry_pass ? alu_carry : 1'b0;
            end
            if ((state == RESP) && rsp_ready) begin
                ops_done <= ops_done + 8'd1;
            end
        end
    end

    assign alu_a   = lat_a;
    assign alu_b   = lat_b;
    assign alu_sel = lat_sel;
    assign rsp_id  = lat_id;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives alu_arbiter with a behavioural ALU attached and
// checks responses against expected values queued at grant time.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [7:0]  r0_a, r0_b, r1_a, r1_b;
    logic [3:0]  r0_sel, r1_sel;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_carry, alu_zflag;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_carry, rsp_zflag;
    logic        busy;
    logic [7:0]  ops_done;

    typedef struct {
        logic        id;
        logic [15:0] result;
        logic        carry;
        logic        zflag;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         fails  = 0;
    logic [7:0] exp_ops = 8'd0;

    alu_arbiter #(.DATA_W(8), .SEL_W(4)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zflag(alu_zflag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zflag(rsp_zflag),
        .busy(busy), .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational ALU; undefined opcodes return 0 with carry set
    always_comb begin
        alu_result = 16'h0000;
        alu_carry  = 1'b0;
        case (alu_sel)
            4'd0: begin alu_result = {8'h00, alu_a} + {8'h00, alu_b}; alu_carry = alu_result[8]; end
            4'd1: begin alu_result = {8'h00, alu_a} - {8'h00, alu_b}; alu_carry = (alu_a < alu_b); end
            4'd2: begin alu_result = alu_a * alu_b; alu_carry = |alu_result[15:8]; end
            4'd3: alu_result = {8'h00, alu_a & alu_b};
            4'd4: alu_result = {8'h00, alu_a | alu_b};
            4'd5: alu_result = {8'h00, ~(alu_a & alu_b)};
            4'd6: alu_result = {8'h00, ~(alu_a | alu_b)};
            4'd7: alu_result = {8'h00, alu_a ^ alu_b};
            default: begin alu_result = 16'h0000; alu_carry = 1'b1; end
        endcase
        alu_zflag = (alu_result == 16'h0000);
    end

    localparam logic       TI [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [7:0] TA [6] = '{8'd200, 8'd5, 8'd3, 8'd16, 8'hF0, 8'd7};
    localparam logic [7:0] TB [6] = '{8'd100, 8'd5, 8'd5, 8'd16, 8'h3C, 8'd9};
    localparam logic [3:0] TS [6] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd5, 4'd12};
    localparam logic [15:0] TR [6] = '{16'h012C, 16'h0000, 16'hFFFE, 16'h0100, 16'h00CF, 16'h0000};
    localparam logic       TC [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic       TZ [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic test_reset();
        rst = 1'b1;
        r0_valid = 1'b1;
        r0_a = 8'h55; r0_b = 8'h11; r0_sel = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (r0_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready: got %b expected 0", r0_ready); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_sel !== 4'h0) begin fails++; $display("[TB] FAIL reset_alu_ops: got %h/%h/%h expected 0", alu_a, alu_b, alu_sel); end
        checks++; if (rsp_result !== 16'h0 || rsp_carry !== 1'b0 || rsp_zflag !== 1'b0 || rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp: got %h %b %b %b expected 0", rsp_result, rsp_carry, rsp_zflag, rsp_id); end
        checks++; if (ops_done !== 8'd0) begin fails++; $display("[TB] FAIL reset_ops_done: got %0d expected 0", ops_done); end
        r0_valid = 1'b0;
        rst = 1'b0;
        exp_ops = 8'd0;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ra0 [2] = '{8'd10, 8'd7};
        logic [7:0]  rb0 [2] = '{8'd3, 8'd2};
        logic [3:0]  rs0 [2] = '{4'd0, 4'd1};
        logic [15:0] rr0 [2] = '{16'd13, 16'd5};
        logic [7:0]  ra1 [2] = '{8'd4, 8'd9};
        logic [7:0]  rb1 [2] = '{8'd4, 8'd1};
        logic [3:0]  rs1 [2] = '{4'd7, 4'd4};
        logic [15:0] rr1 [2] = '{16'd0, 16'd9};
        logic        rz1 [2] = '{1'b1, 1'b0};
        int i0 = 0, i1 = 0, ng = 0, done = 0, stall = 5;
        exp_t e;
        for (int cyc = 0; cyc < 200 && done < 4; cyc++) begin
            @(negedge clk);
            r0_valid = (i0 < 2);
            r1_valid = (i1 < 2);
            if (i0 < 2) begin r0_a = ra0[i0]; r0_b = rb0[i0]; r0_sel = rs0[i0]; end
            if (i1 < 2) begin r1_a = ra1[i1]; r1_b = rb1[i1]; r1_sel = rs1[i1]; end
            rsp_ready = (rsp_valid === 1'b1) && (stall == 0);
            #1;
            if (r0_ready === 1'b1 && r1_ready === 1'b1) begin
                checks++; fails++; $display("[TB] FAIL both_ready: got 1/1 expected at most one");
            end else if (r0_ready === 1'b1 || r1_ready === 1'b1) begin
                checks++;
                if (r1_ready !== ng[0]) begin fails++; $display("[TB] FAIL rr_order: grant %0d got r%0d expected r%0d", ng, r1_ready, ng[0]); end
                if (r0_ready === 1'b1) begin
                    sb.push_back('{1'b0, rr0[i0], 1'b0, 1'b0}); i0++;
                end else begin
                    sb.push_back('{1'b1, rr1[i1], 1'b0, rz1[i1]}); i1++;
                end
                ng++;
            end
            if (rsp_valid === 1'b1 && sb.size() > 0) begin
                e = sb[0];
                checks++;
                if (rsp_result !== e.result || rsp_id !== e.id || rsp_carry !== e.carry || rsp_zflag !== e.zflag) begin
                    fails++; $display("[TB] FAIL rr_rsp: got r=%h id=%b c=%b z=%b expected r=%h id=%b c=%b z=%b",
                                      rsp_result, rsp_id, rsp_carry, rsp_zflag, e.result, e.id, e.carry, e.zflag);
                end
                if (rsp_ready === 1'b1) begin
                    void'(sb.pop_front());
                    done++;
                    exp_ops++;
                end else begin
                    stall--;
                    checks++;
                    if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall_grant: got %b/%b expected 0/0", r0_ready, r1_ready); end
                end
            end
        end
        @(negedge clk);
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        checks++; if (done != 4) begin fails++; $display("[TB] FAIL rr_timeout: got %0d responses expected 4", done); end
        checks++; if (ops_done !== exp_ops || exp_ops !== 8'd4) begin fails++; $display("[TB] FAIL rr_ops_done: got %0d expected 4", ops_done); end
        sb.delete();
    endtask

    task automatic test_arith();
        exp_t e;
        int cnt;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (TI[k]) begin
                r1_valid = 1'b1; r1_a = TA[k]; r1_b = TB[k]; r1_sel = TS[k];
            end else begin
                r0_valid = 1'b1; r0_a = TA[k]; r0_b = TB[k]; r0_sel = TS[k];
            end
            #1;
            checks++;
            if ((TI[k] ? r1_ready : r0_ready) !== 1'b1 || (TI[k] ? r0_ready : r1_ready) !== 1'b0) begin
                fails++; $display("[TB] FAIL op%0d_grant: got r0=%b r1=%b expected only r%0d", k, r0_ready, r1_ready, TI[k]);
            end
            sb.push_back('{TI[k], TR[k], TC[k], TZ[k]});
            @(negedge clk);
            #1;
            checks++;
            if (busy !== 1'b1 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
                fails++; $display("[TB] FAIL op%0d_exec: got busy=%b r0=%b r1=%b expected 1/0/0", k, busy, r0_ready, r1_ready);
            end
            r0_valid = 1'b0; r1_valid = 1'b0;
            checks++;
            if (alu_a !== TA[k] || alu_b !== TB[k] || alu_sel !== TS[k]) begin
                fails++; $display("[TB] FAIL op%0d_alu_in: got %h/%h/%h expected %h/%h/%h", k, alu_a, alu_b, alu_sel, TA[k], TB[k], TS[k]);
            end
            cnt = 0;
            while (rsp_valid !== 1'b1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (cnt != 2) begin fails++; $display("[TB] FAIL op%0d_latency: got %0d expected 2 cycles after exec", k, cnt); end
            e = sb.pop_front();
            checks++;
            if (rsp_result !== e.result) begin fails++; $display("[TB] FAIL op%0d_result: got %h expected %h", k, rsp_result, e.result); end
            checks++;
            if (rsp_carry !== e.carry || rsp_zflag !== e.zflag) begin fails++; $display("[TB] FAIL op%0d_flags: got c=%b z=%b expected c=%b z=%b", k, rsp_carry, rsp_zflag, e.carry, e.zflag); end
            checks++;
            if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL op%0d_id: got %b expected %b", k, rsp_id, e.id); end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            exp_ops++;
            checks++;
            if (ops_done !== exp_ops || rsp_valid !== 1'b0) begin
                fails++; $display("[TB] FAIL op%0d_done: got ops=%0d valid=%b expected ops=%0d valid=0", k, ops_done, rsp_valid, exp_ops);
            end
        end
    endtask

    task automatic test_reset_in_resp();
        int cnt = 0;
        @(negedge clk);
        r1_valid = 1'b1; r1_a = 8'hFF; r1_b = 8'h0F; r1_sel = 4'd3;
        @(negedge clk);
        r1_valid = 1'b0;
        while (rsp_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL rir_reach_resp: got %b expected 1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 8'd1; r0_b = 8'd2; r0_sel = 4'd0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || r0_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL rir_state: got valid=%b busy=%b ready=%b expected 0/0/0", rsp_valid, busy, r0_ready);
        end
        checks++;
        if (ops_done !== 8'd0 || rsp_result !== 16'h0 || rsp_id !== 1'b0 || alu_a !== 8'h0) begin
            fails++; $display("[TB] FAIL rir_clear: got ops=%0d res=%h id=%b a=%h expected 0", ops_done, rsp_result, rsp_id, alu_a);
        end
        r0_valid = 1'b0;
        rst = 1'b0;
        exp_ops = 8'd0;
        sb.delete();
    endtask

    task automatic test_wrap();
        logic [8:0] hs = 9'd0;
        @(negedge clk);
        r0_valid = 1'b1; r0_a = 8'd1; r0_b = 8'd1; r0_sel = 4'd0;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && hs < 9'd256; cyc++) begin
            @(negedge clk);
            checks++;
            if (ops_done !== hs[7:0]) begin fails++; $display("[TB] FAIL wrap_count: got %0d expected %0d", ops_done, hs[7:0]); end
            if (rsp_valid === 1'b1) hs++;
        end
        r0_valid = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (hs != 9'd256) begin fails++; $display("[TB] FAIL wrap_timeout: got %0d handshakes expected 256", hs); end
        checks++;
        if (ops_done !== 8'd0) begin fails++; $display("[TB] FAIL wrap_zero: got %0d expected 0", ops_done); end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b0;
        r0_a = '0; r0_b = '0; r0_sel = '0;
        r1_a = '0; r1_b = '0; r1_sel = '0;
        test_reset();
        test_back_to_back();
        test_arith();
        test_reset_in_resp();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand width; SHALL match the 8-bit ALU operand ports.
REQ-002 Parameter SEL_W, default 4, opcode width; SHALL match the ALU select port.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 r0_valid, r1_valid  input  1  requester N has an operation pending.
REQ-006 r0_ready, r1_ready  output  1  operation accepted from requester N this cycle.
REQ-007 r0_a/r0_b, r1_a/r1_b  input  DATA_W  requester N operands.
REQ-008 r0_sel, r1_sel  input  SEL_W  requester N opcode: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 NAND, 6 NOR, 7 XOR.
REQ-009 alu_a, alu_b  output  DATA_W  operands driven to the combinational ALU.
REQ-010 alu_sel  output  SEL_W  opcode driven to the ALU.
REQ-011 alu_result  input  16  ALU result; alu_carry, alu_zflag  input  1  ALU flags.
REQ-012 rsp_valid  output  1  response available; rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_id  output  1  index of the requester that issued the response.
REQ-014 rsp_result  output  16; rsp_carry, rsp_zflag  output  1  registered ALU outputs.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 ops_done  output  8  count of completed responses.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, CAPT and RESP.
REQ-018 IDLE: if any rN_valid, grant one requester, assert its rN_ready for exactly that cycle, latch its a/b/sel and id, go to EXEC; otherwise stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it; the post-reset last-grant pointer SHALL favour r0.
REQ-020 rN_ready SHALL be low in EXEC, CAPT and RESP; at most one rN_ready SHALL be high per cycle.
REQ-021 alu_a, alu_b and alu_sel SHALL drive the latched operands continuously and change only on a grant.
REQ-022 EXEC: one settle cycle, then go to CAPT unconditionally.
REQ-023 CAPT: register alu_result into rsp_result and alu_zflag into rsp_zflag, and go to RESP.
REQ-024 rsp_carry SHALL take alu_carry when the latched sel is 0 or 1, and 0 for every other opcode.
REQ-025 Opcodes 8-15 SHALL be accepted and completed normally; the response carries whatever the ALU returns (result 0).
REQ-026 RESP: rsp_valid SHALL be high; rsp_result, rsp_carry, rsp_zflag and rsp_id SHALL hold stable until rsp_ready is sampled high, then return to IDLE.
REQ-027 Latency: grant in cycle N SHALL give rsp_valid high in cycle N+3; the earliest next grant SHALL come one cycle after the response handshake.
REQ-028 ops_done SHALL increment by 1 on each response handshake and wrap 255 -> 0.
REQ-029 Requests arriving while busy SHALL be held off (ready low), not dropped; requesters hold valid and operands until ready.

Reset
REQ-030 While rst is high at a rising clk edge: state IDLE; last-grant pointer favours r0; rN_ready 0; rsp_valid 0; busy 0.
REQ-031 While rst is high at a rising clk edge: alu_a, alu_b, alu_sel, rsp_result, rsp_carry, rsp_zflag, rsp_id and ops_done all 0.
REQ-032 Reset asserted in any state, including RESP with rsp_valid high, SHALL abandon the operation without a response; the first grant SHALL occur no earlier than the first cycle after rst deasserts.

Verification
REQ-033 r0 ADD a=200 b=100 -> r0_ready one cycle; 3 cycles later rsp_valid, rsp_result=0x012C, carry=1, zflag=0, id=0.
REQ-034 r1 SUB a=5 b=5 -> rsp_result=0x0000, zflag=1, carry=0, id=1; r1 SUB a=3 b=5 -> result=0xFFFE, carry=1, zflag=0.
REQ-035 r0 MUL a=16 b=16 -> result=0x0100, carry=0 (forced), zflag=0.
REQ-036 Both valid continuously for 4 ops -> grants r0,r1,r0,r1 and ops_done ends at 4; with rsp_ready held low 5 cycles, outputs stay stable and no new grant occurs.
REQ-037 rst pulsed during RESP -> rsp_valid 0 the next cycle, no handshake, ops_done=0; ops_done after 256 responses reads 0.
